// File: rtl/memory_pkg.sv
// Shared encodings for the Memory1/Memory2 pipeline segments: access kind,
// access length and the Memory1 lookup FSM states.
package memory_pkg;

  typedef enum logic [1:0] {
    MRW_NONE  = 2'b00,
    MRW_READ  = 2'b01,
    MRW_WRITE = 2'b10,
    MRW_RSVD  = 2'b11
  } mem_rw_e;

  typedef enum logic [2:0] {
    LEN_B  = 3'b000,
    LEN_H  = 3'b001,
    LEN_W  = 3'b010,
    LEN_BU = 3'b100,
    LEN_HU = 3'b101
  } num_len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOOKUP = 2'b01,
    ST_DONE   = 2'b10
  } mem_state_e;

  // The reserved encoding 11 behaves like "no memory access".
  function automatic logic is_mem_op(input logic [1:0] rw);
    return (rw == MRW_READ) || (rw == MRW_WRITE);
  endfunction

endpackage

// File: rtl/memory1_align_check.sv
// Natural-alignment check for a load/store: halfwords need an even address,
// words need a multiple of four, bytes are always aligned.
module memory1_align_check
  import memory_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [2:0] number_length,
  output logic       aligned
);

  // Unused length encodings carry no alignment constraint.
  always_comb begin
    aligned = 1'b1;
    case (number_length)
      LEN_H, LEN_HU: aligned = ~addr[0];
      LEN_W:         aligned = (addr == 2'b00);
      default:       aligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory1.sv
// Memory1 pipeline segment: latches the Execute results, checks alignment and
// performs the TLB lookup handshake, stalling upstream while it is in flight.
module memory1
  import memory_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TLB_W  = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] ex_result_RegInput,
  input  logic [ADDR_W-1:0] store_data_RegInput,
  input  logic [4:0]        rd_index_RegInput,
  input  logic [2:0]        number_length_RegInput,
  input  logic [1:0]        memory_rw_RegInput,
  input  logic              writeback_valid_RegInput,
  input  logic              writeback_src_RegInput,
  input  logic              stall_RegInput,
  input  logic              clear_RegInput,
  output logic [ADDR_W-1:0] ex_result,
  output logic [ADDR_W-1:0] store_data,
  output logic [4:0]        rd_index,
  output logic [2:0]        number_length,
  output logic [1:0]        memory_rw,
  output logic              writeback_valid,
  output logic              writeback_src,
  output logic              clear,
  output logic              tlb_req,
  output logic [ADDR_W-1:0] v_addr,
  input  logic              tlb_ready,
  input  logic              tlb_hit,
  input  logic [TLB_W-1:0]  tlb_read,
  output logic              mem2_tlb_hit,
  output logic [TLB_W-1:0]  mem2_tlb_read,
  output logic              stall_req,
  output logic              ale,
  output logic              tlb_refill
);

  mem_state_e state, state_next;
  logic       aligned;
  logic       mem_op_in;
  logic       misaligned;
  logic       do_capture;
  logic       do_latch;
  logic [1:0] memory_rw_q;
  logic       writeback_valid_q;

  memory1_align_check u_align (
    .addr          (ex_result_RegInput[1:0]),
    .number_length (number_length_RegInput),
    .aligned       (aligned)
  );

  assign mem_op_in  = is_mem_op(memory_rw_RegInput);
  assign misaligned = mem_op_in & ~aligned;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Clear wins over everything; a lookup in flight ignores the hazard stall,
  // IDLE and DONE both behave as "ready to accept the next instruction".
  always_comb begin
    state_next = state;
    do_capture = 1'b0;
    do_latch   = 1'b0;
    tlb_req    = 1'b0;
    stall_req  = 1'b0;
    if (clear_RegInput) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_LOOKUP: begin
          if (tlb_ready) begin
            do_latch   = 1'b1;
            state_next = ST_DONE;
          end
        end
        default: begin
          if (!stall_RegInput) begin
            do_capture = 1'b1;
            state_next = (mem_op_in && aligned) ? ST_LOOKUP : ST_IDLE;
          end
        end
      endcase
    end
    if (state == ST_LOOKUP) begin
      tlb_req   = 1'b1;
      stall_req = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_result         <= '0;
      store_data        <= '0;
      rd_index          <= '0;
      number_length     <= '0;
      memory_rw_q       <= '0;
      writeback_valid_q <= 1'b0;
      writeback_src     <= 1'b0;
      clear             <= 1'b0;
      ale               <= 1'b0;
      tlb_refill        <= 1'b0;
      mem2_tlb_hit      <= 1'b0;
      mem2_tlb_read     <= '0;
    end else begin
      clear <= clear_RegInput;
      if (clear_RegInput) begin
        memory_rw_q       <= MRW_NONE;
        writeback_valid_q <= 1'b0;
        ale               <= 1'b0;
        tlb_refill        <= 1'b0;
      end else if (do_latch) begin
        mem2_tlb_hit  <= tlb_hit;
        mem2_tlb_read <= tlb_read;
        // A miss turns the access into a bubble and raises the refill exception.
        if (!tlb_hit) begin
          tlb_refill        <= 1'b1;
          memory_rw_q       <= MRW_NONE;
          writeback_valid_q <= 1'b0;
        end
      end else if (do_capture) begin
        ex_result         <= ex_result_RegInput;
        store_data        <= store_data_RegInput;
        rd_index          <= rd_index_RegInput;
        number_length     <= number_length_RegInput;
        writeback_src     <= writeback_src_RegInput;
        memory_rw_q       <= misaligned ? MRW_NONE : memory_rw_RegInput;
        writeback_valid_q <= misaligned ? 1'b0 : writeback_valid_RegInput;
        ale               <= misaligned;
        tlb_refill        <= 1'b0;
        mem2_tlb_hit      <= 1'b0;
      end
    end
  end

  // Memory2 sees a bubble for as long as the lookup is outstanding.
  assign memory_rw       = (state == ST_LOOKUP) ? MRW_NONE : memory_rw_q;
  assign writeback_valid = (state == ST_LOOKUP) ? 1'b0 : writeback_valid_q;
  assign v_addr          = ex_result;

endmodule

// File: tb/tb_memory1.sv
// Self-checking bench for memory1: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_memory1;

  localparam int ADDR_W = 32;
  localparam int TLB_W  = 64;

  logic              clk  = 1'b0;
  logic              rstn = 1'b1;
  logic [ADDR_W-1:0] ex_result_RegInput = '0;
  logic [ADDR_W-1:0] store_data_RegInput = '0;
  logic [4:0]        rd_index_RegInput = '0;
  logic [2:0]        number_length_RegInput = '0;
  logic [1:0]        memory_rw_RegInput = '0;
  logic              writeback_valid_RegInput = 1'b0;
  logic              writeback_src_RegInput = 1'b0;
  logic              stall_RegInput = 1'b0;
  logic              clear_RegInput = 1'b0;
  logic              tlb_ready = 1'b0;
  logic              tlb_hit = 1'b0;
  logic [TLB_W-1:0]  tlb_read = '0;

  logic [ADDR_W-1:0] ex_result, store_data, v_addr;
  logic [4:0]        rd_index;
  logic [2:0]        number_length;
  logic [1:0]        memory_rw;
  logic              writeback_valid, writeback_src, clear, tlb_req;
  logic              mem2_tlb_hit, stall_req, ale, tlb_refill;
  logic [TLB_W-1:0]  mem2_tlb_read;

  int   error_count = 0;
  int   check_count = 0;
  logic check_en    = 1'b0;

  always #5 clk = ~clk;

  memory1 #(.ADDR_W(ADDR_W), .TLB_W(TLB_W)) dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .ex_result_RegInput       (ex_result_RegInput),
    .store_data_RegInput      (store_data_RegInput),
    .rd_index_RegInput        (rd_index_RegInput),
    .number_length_RegInput   (number_length_RegInput),
    .memory_rw_RegInput       (memory_rw_RegInput),
    .writeback_valid_RegInput (writeback_valid_RegInput),
    .writeback_src_RegInput   (writeback_src_RegInput),
    .stall_RegInput           (stall_RegInput),
    .clear_RegInput           (clear_RegInput),
    .ex_result                (ex_result),
    .store_data               (store_data),
    .rd_index                 (rd_index),
    .number_length            (number_length),
    .memory_rw                (memory_rw),
    .writeback_valid          (writeback_valid),
    .writeback_src            (writeback_src),
    .clear                    (clear),
    .tlb_req                  (tlb_req),
    .v_addr                   (v_addr),
    .tlb_ready                (tlb_ready),
    .tlb_hit                  (tlb_hit),
    .tlb_read                 (tlb_read),
    .mem2_tlb_hit             (mem2_tlb_hit),
    .mem2_tlb_read            (mem2_tlb_read),
    .stall_req                (stall_req),
    .ale                      (ale),
    .tlb_refill               (tlb_refill)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: one "busy" flag for an outstanding lookup plus the
  // architecturally visible segment contents.
  logic              m_busy = 1'b0;
  logic [ADDR_W-1:0] m_ex = '0, m_sd = '0;
  logic [4:0]        m_rd = '0;
  logic [2:0]        m_nl = '0;
  logic [1:0]        m_rw = '0;
  logic              m_wbv = 1'b0, m_wbs = 1'b0, m_clr = 1'b0;
  logic              m_ale = 1'b0, m_refill = 1'b0, m_hit = 1'b0;
  logic [TLB_W-1:0]  m_read = '0;

  function automatic int access_bytes(input logic [2:0] nl);
    case (nl)
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 1;
    endcase
  endfunction

  function automatic bit is_access(input logic [1:0] rw);
    return (rw == 2'd1) || (rw == 2'd2);
  endfunction

  function automatic bit is_misaligned(input logic [1:0] rw, input logic [31:0] addr, input logic [2:0] nl);
    return is_access(rw) && ((int'(addr[1:0]) % access_bytes(nl)) != 0);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_ex <= '0; m_sd <= '0; m_rd <= '0; m_nl <= '0; m_rw <= '0;
      m_wbv <= 1'b0; m_wbs <= 1'b0; m_clr <= 1'b0; m_ale <= 1'b0; m_refill <= 1'b0;
      m_hit <= 1'b0; m_read <= '0;
    end else begin
      m_clr <= clear_RegInput;
      if (clear_RegInput) begin
        m_busy <= 1'b0; m_wbv <= 1'b0; m_rw <= 2'd0; m_ale <= 1'b0; m_refill <= 1'b0;
      end else if (m_busy) begin
        if (tlb_ready) begin
          m_busy <= 1'b0;
          m_hit  <= tlb_hit;
          m_read <= tlb_read;
          if (!tlb_hit) begin
            m_refill <= 1'b1; m_rw <= 2'd0; m_wbv <= 1'b0;
          end
        end
      end else if (!stall_RegInput) begin
        m_ex <= ex_result_RegInput; m_sd <= store_data_RegInput; m_rd <= rd_index_RegInput;
        m_nl <= number_length_RegInput; m_wbs <= writeback_src_RegInput;
        m_refill <= 1'b0; m_hit <= 1'b0;
        if (is_misaligned(memory_rw_RegInput, ex_result_RegInput, number_length_RegInput)) begin
          m_ale <= 1'b1; m_rw <= 2'd0; m_wbv <= 1'b0; m_busy <= 1'b0;
        end else begin
          m_ale  <= 1'b0;
          m_rw   <= memory_rw_RegInput;
          m_wbv  <= writeback_valid_RegInput;
          m_busy <= is_access(memory_rw_RegInput);
        end
      end
    end
  end

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("ex_result", 64'(ex_result), 64'(m_ex));
      checkOutput("store_data", 64'(store_data), 64'(m_sd));
      checkOutput("rd_index", 64'(rd_index), 64'(m_rd));
      checkOutput("number_length", 64'(number_length), 64'(m_nl));
      checkOutput("memory_rw", 64'(memory_rw), m_busy ? 64'h0 : 64'(m_rw));
      checkOutput("writeback_valid", 64'(writeback_valid), m_busy ? 64'h0 : 64'(m_wbv));
      checkOutput("writeback_src", 64'(writeback_src), 64'(m_wbs));
      checkOutput("clear", 64'(clear), 64'(m_clr));
      checkOutput("tlb_req", 64'(tlb_req), 64'(m_busy));
      checkOutput("stall_req", 64'(stall_req), 64'(m_busy));
      checkOutput("ale", 64'(ale), 64'(m_ale));
      checkOutput("tlb_refill", 64'(tlb_refill), 64'(m_refill));
      checkOutput("mem2_tlb_hit", 64'(mem2_tlb_hit), 64'(m_hit));
      checkOutput("mem2_tlb_read", mem2_tlb_read, m_read);
      if (m_busy) checkOutput("v_addr", 64'(v_addr), 64'(m_ex));
    end
  end

  task automatic applyStimulus(input logic [1:0] rw, input logic [2:0] nl, input logic [31:0] addr,
                               input logic [31:0] sd, input logic [4:0] rd, input logic wbv,
                               input logic wbs, input logic stall, input logic clr);
    memory_rw_RegInput       = rw;
    number_length_RegInput   = nl;
    ex_result_RegInput       = addr;
    store_data_RegInput      = sd;
    rd_index_RegInput        = rd;
    writeback_valid_RegInput = wbv;
    writeback_src_RegInput   = wbs;
    stall_RegInput           = stall;
    clear_RegInput           = clr;
  endtask

  task automatic setTlb(input logic ready, input logic hit, input logic [63:0] data);
    tlb_ready = ready;
    tlb_hit   = hit;
    tlb_read  = data;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", error_count);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [2:0] len_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_clear", 64'(clear), 64'h0);
    checkOutput("reset_tlb_req", 64'(tlb_req), 64'h0);
    checkOutput("reset_stall_req", 64'(stall_req), 64'h0);
    checkOutput("reset_ex_result", 64'(ex_result), 64'h0);
    rstn     = 1'b1;
    check_en = 1'b1;
    applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();

    // Load word with a three-cycle TLB latency and a hit.
    applyStimulus(2'b01, 3'b010, 32'h0000_1004, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    setTlb(1'b0, 1'b0, 64'h0);
    stepCycle();
    checkOutput("ldw_l1_stall_req", 64'(stall_req), 64'h1);
    checkOutput("ldw_l1_v_addr", 64'(v_addr), 64'h1004);
    checkOutput("ldw_l1_bubble_rw", 64'(memory_rw), 64'h0);
    checkOutput("ldw_l1_bubble_wbv", 64'(writeback_valid), 64'h0);
    applyStimulus(2'b10, 3'b000, 32'hFFFF_FFF1, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("ldw_l2_stall_req", 64'(stall_req), 64'h1);
    checkOutput("ldw_l2_ex_held", 64'(ex_result), 64'h1004);
    stepCycle();
    checkOutput("ldw_l3_stall_req", 64'(stall_req), 64'h1);
    setTlb(1'b1, 1'b1, 64'h0000_0000_0000_ABCD);
    stall_RegInput = 1'b1;
    stepCycle();
    setTlb(1'b0, 1'b0, 64'h0);
    checkOutput("ldw_done_stall_req", 64'(stall_req), 64'h0);
    checkOutput("ldw_done_rw", 64'(memory_rw), 64'h1);
    checkOutput("ldw_done_wbv", 64'(writeback_valid), 64'h1);
    checkOutput("ldw_done_hit", 64'(mem2_tlb_hit), 64'h1);
    checkOutput("ldw_done_read", mem2_tlb_read, 64'hABCD);

    // Misaligned halfword store.
    applyStimulus(2'b10, 3'b001, 32'h0000_1003, 32'h55AA, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("sth_ale", 64'(ale), 64'h1);
    checkOutput("sth_rw", 64'(memory_rw), 64'h0);
    checkOutput("sth_wbv", 64'(writeback_valid), 64'h0);
    checkOutput("sth_tlb_req", 64'(tlb_req), 64'h0);
    stall_RegInput = 1'b1;
    stepCycle();
    checkOutput("sth_tlb_req_later", 64'(tlb_req), 64'h0);

    // Load byte that misses in the TLB.
    applyStimulus(2'b01, 3'b000, 32'h0000_2001, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("ldb_tlb_req", 64'(tlb_req), 64'h1);
    checkOutput("ldb_ale_cleared", 64'(ale), 64'h0);
    setTlb(1'b1, 1'b0, 64'h1234);
    stall_RegInput = 1'b1;
    stepCycle();
    setTlb(1'b0, 1'b0, 64'h0);
    checkOutput("ldb_refill", 64'(tlb_refill), 64'h1);
    checkOutput("ldb_wbv", 64'(writeback_valid), 64'h0);
    checkOutput("ldb_rw", 64'(memory_rw), 64'h0);

    // Flush while a lookup is outstanding.
    applyStimulus(2'b01, 3'b010, 32'h0000_3000, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("clr_pre_tlb_req", 64'(tlb_req), 64'h1);
    applyStimulus(2'b01, 3'b010, 32'h0000_3000, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("clr_clear", 64'(clear), 64'h1);
    checkOutput("clr_tlb_req", 64'(tlb_req), 64'h0);
    checkOutput("clr_stall_req", 64'(stall_req), 64'h0);
    checkOutput("clr_wbv", 64'(writeback_valid), 64'h0);
    clear_RegInput = 1'b0;
    stepCycle();
    checkOutput("clr_released", 64'(clear), 64'h0);

    // ALU result held by a two-cycle hazard stall.
    applyStimulus(2'b00, 3'b010, 32'hDEAD_BEEF, 32'h1111, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("alu_ex", 64'(ex_result), 64'hDEAD_BEEF);
    checkOutput("alu_wbv", 64'(writeback_valid), 64'h1);
    applyStimulus(2'b00, 3'b000, 32'h0000_0BAD, 32'h2222, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      checkOutput("alu_hold_ex", 64'(ex_result), 64'hDEAD_BEEF);
      checkOutput("alu_hold_rd", 64'(rd_index), 64'h7);
      checkOutput("alu_hold_stall_req", 64'(stall_req), 64'h0);
    end
    stall_RegInput = 1'b0;
    stepCycle();
    checkOutput("alu_next_ex", 64'(ex_result), 64'h0BAD);

    // Reset in the middle of a lookup, then a stale tlb_ready.
    applyStimulus(2'b01, 3'b010, 32'h0000_4000, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rst_pre_tlb_req", 64'(tlb_req), 64'h1);
    applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_tlb_req", 64'(tlb_req), 64'h0);
    checkOutput("rst_stall_req", 64'(stall_req), 64'h0);
    checkOutput("rst_ex", 64'(ex_result), 64'h0);
    checkOutput("rst_wbv", 64'(writeback_valid), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    setTlb(1'b1, 1'b1, 64'hFFFF);
    stepCycle();
    setTlb(1'b0, 1'b0, 64'h0);
    checkOutput("rst_late_tlb_req", 64'(tlb_req), 64'h0);
    checkOutput("rst_late_hit", 64'(mem2_tlb_hit), 64'h0);
    checkOutput("rst_late_read", mem2_tlb_read, 64'h0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), len_codes[$urandom_range(0, 4)],
                    $urandom() & (($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF),
                    $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 19) == 0));
      setTlb(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), {$urandom(), $urandom()});
      if ($urandom_range(0, 199) == 0) begin
        #1 rstn = 1'b0;
        #2 rstn = 1'b1;
      end
      stepCycle();
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
